// File: rtl/reg_dump_ctrl_pkg.sv
// Shared definitions for the register-dump block: bus widths, the dump
// FSM state encoding, the default frame header and the data-byte picker.
package reg_dump_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [7:0] DUMP_HDR = 8'hA5;

    // Index byte is byte 0 of each register group, data bytes are 1..4
    localparam logic [2:0] LAST_BYTE_CNT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ADDR = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } dump_state_t;

    // Return data byte k (1..4) of a register word in the selected order.
    // With msb_first set, k=1 is word[31:24]; otherwise k=1 is word[7:0].
    function automatic logic [7:0] word_byte(input logic [DATA_W-1:0] word,
                                             input logic [2:0]        k,
                                             input logic              msb_first);
        logic [1:0] lane;
        logic [7:0] b;
        lane = 2'(k - 3'd1);
        if (msb_first) begin
            lane = 2'd3 - lane;
        end
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/reg_dump_ctrl_ser.sv
// Byte serializer for the register dump stream.
// Presents either a single header byte or a 5-byte register group
// ({index}, then 4 word bytes) over a valid/ready handshake. byte_o and
// valid are registered and only change on load or on an accepted byte.
module reg_dump_ctrl_ser
    import reg_dump_ctrl_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  i_load_hdr,
    input  logic [7:0]            i_hdr_byte,
    input  logic                  i_load,
    input  logic [REG_ADDR_W-1:0] i_index,
    input  logic [DATA_W-1:0]     i_word,
    input  logic                  i_ready,
    output logic [7:0]            o_byte,
    output logic                  o_valid,
    output logic                  o_accept,
    output logic                  o_last
);

    logic [DATA_W-1:0] r_word;
    logic [2:0]        r_byte_cnt;
    logic [7:0]        r_byte;
    logic              r_valid;
    logic              r_is_hdr;
    logic              r_last;

    logic              w_accept;
    logic [2:0]        w_next_cnt;

    assign w_accept   = r_valid & i_ready;
    assign w_next_cnt = r_byte_cnt + 3'd1;

    // Load header or a register group; advance one byte per accepted transfer
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_word     <= '0;
            r_byte_cnt <= '0;
            r_byte     <= '0;
            r_valid    <= 1'b0;
            r_is_hdr   <= 1'b0;
            r_last     <= 1'b0;
        end else if (i_load_hdr) begin
            r_byte     <= i_hdr_byte;
            r_valid    <= 1'b1;
            r_is_hdr   <= 1'b1;
            r_byte_cnt <= '0;
            r_last     <= 1'b0;
        end else if (i_load) begin
            r_word     <= i_word;
            r_byte     <= {3'b000, i_index};
            r_valid    <= 1'b1;
            r_is_hdr   <= 1'b0;
            r_byte_cnt <= '0;
            r_last     <= 1'b0;
        end else if (w_accept) begin
            if (r_is_hdr || r_last) begin
                // Group finished: drop valid until the next load
                r_valid  <= 1'b0;
                r_is_hdr <= 1'b0;
                r_last   <= 1'b0;
            end else begin
                r_byte_cnt <= w_next_cnt;
                r_byte     <= word_byte(r_word, w_next_cnt, MSB_FIRST);
                r_last     <= (w_next_cnt == LAST_BYTE_CNT);
            end
        end
    end

    assign o_byte   = r_byte;
    assign o_valid  = r_valid;
    assign o_accept = w_accept;
    assign o_last   = r_last & ~r_is_hdr;

endmodule

// File: rtl/reg_dump_ctrl.sv
// Register-file dump initiator.
// On start_i, walks FIRST_REG..LAST_REG through one register-file read
// port and streams a header byte followed by {index, 4 data bytes} per
// register. Each word is sampled in its own ADDR cycle, so later CPU writes
// to registers not yet reached show up in the dump.
//
// state | meaning
// IDLE  | waiting for start_i
// HDR   | header byte presented, waiting for accept
// ADDR  | rR_o = index, word captured at end of cycle
// SEND  | 5 bytes of the current register being streamed
// DONE  | one-cycle done_o pulse
module reg_dump_ctrl
    import reg_dump_ctrl_pkg::*;
#(
    parameter int         FIRST_REG = 0,
    parameter int         LAST_REG  = 31,
    parameter logic [7:0] HDR_BYTE  = DUMP_HDR,
    parameter bit         MSB_FIRST = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic [REG_ADDR_W-1:0] rR_o,
    input  logic [DATA_W-1:0]     rD_i,
    output logic [7:0]            byte_o,
    output logic                  byte_valid_o,
    input  logic                  byte_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    if (FIRST_REG < 0 || FIRST_REG > 31 || LAST_REG < FIRST_REG || LAST_REG > 31) begin : g_bad_range
        $error("reg_dump_ctrl: FIRST_REG/LAST_REG out of range");
    end

    localparam logic [REG_ADDR_W-1:0] LP_FIRST = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LP_LAST  = REG_ADDR_W'(LAST_REG);

    dump_state_t           r_state;
    logic [REG_ADDR_W-1:0] r_index;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_load_hdr;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_last;

    // Header is loaded on the same edge that leaves IDLE, the word on the
    // edge that leaves ADDR, so byte_o/valid stay registered with the state.
    assign w_load_hdr = (r_state == ST_IDLE) & start_i;
    assign w_load     = (r_state == ST_ADDR);

    reg_dump_ctrl_ser #(
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .i_load_hdr (w_load_hdr),
        .i_hdr_byte (HDR_BYTE),
        .i_load     (w_load),
        .i_index    (r_index),
        .i_word     (rD_i),
        .i_ready    (byte_ready_i),
        .o_byte     (byte_o),
        .o_valid    (byte_valid_o),
        .o_accept   (w_accept),
        .o_last     (w_last)
    );

    // Dump sequencing: state, register index, busy and done flags
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_index <= LP_FIRST;
                        r_busy  <= 1'b1;
                        r_state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_accept) begin
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_accept && w_last) begin
                        if (r_index == LP_LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_index <= r_index + 5'd1;
                            r_state <= ST_ADDR;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rR_o   = r_index;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule
